// File: rtl/present_test_sequencer.sv
// Test-vector sequencer for a PRESENT core: walks every vector address, loads the core,
// waits for a fresh done and tallies pass, fail and timeout results.
module present_test_sequencer #(
  parameter  int TEST_CASE_SIZE = 32,
  parameter  int SETUP_CYCLES   = 2,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int AW             = $clog2(TEST_CASE_SIZE)
) (
  input  logic          sig_mstr_clk,
  input  logic          sig_in_rst,
  input  logic          sig_in_start,
  input  logic          sig_in_done,
  input  logic          sig_in_valid,
  output logic [AW-1:0] seq_selected,
  output logic          sig_out_load,
  output logic          sig_out_busy,
  output logic          sig_out_finished,
  output logic [AW:0]   vec_out_pass_cnt,
  output logic [AW:0]   vec_out_fail_cnt,
  output logic [AW-1:0] vec_out_first_fail,
  output logic          sig_out_any_fail,
  output logic          sig_out_timeout
);

  localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [AW-1:0]  LAST_ADDR  = AW'(TEST_CASE_SIZE - 1);
  localparam logic [AW-1:0]  ADDR_ONE   = AW'(1);
  localparam logic [AW:0]    CNT_ONE    = (AW + 1)'(1);
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYCLES - 1);
  localparam logic [SCW-1:0] SETUP_ONE  = SCW'(1);
  localparam logic [TCW-1:0] WAIT_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [TCW-1:0] WAIT_ONE   = TCW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [SCW-1:0] setup_cnt;
  logic [SCW-1:0] setup_cnt_nx;
  logic [TCW-1:0] wait_cnt;
  logic [TCW-1:0] wait_cnt_nx;
  logic           armed;
  logic           armed_nx;
  logic [AW-1:0]  addr_nx;
  logic           load_nx;
  logic           busy_nx;
  logic           finished_nx;
  logic [AW:0]    pass_nx;
  logic [AW:0]    fail_nx;
  logic [AW-1:0]  first_fail_nx;
  logic           any_fail_nx;
  logic           timeout_nx;
  logic           clear_run;
  logic           pass_evt;
  logic           fail_evt;
  logic           timeout_evt;

  // Next-state, address walk and per-vector event decode
  always_comb begin
    state_nx     = state;
    addr_nx      = seq_selected;
    setup_cnt_nx = setup_cnt;
    wait_cnt_nx  = wait_cnt;
    armed_nx     = armed;
    clear_run    = 1'b0;
    pass_evt     = 1'b0;
    fail_evt     = 1'b0;
    timeout_evt  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (sig_in_start) begin
          state_nx     = SETUP;
          addr_nx      = '0;
          setup_cnt_nx = '0;
          clear_run    = 1'b1;
        end else begin
          state_nx = state;
        end
      end
      SETUP: begin
        if (setup_cnt == SETUP_LAST) begin
          state_nx     = LOAD;
          setup_cnt_nx = '0;
        end else begin
          setup_cnt_nx = setup_cnt + SETUP_ONE;
        end
      end
      LOAD: begin
        state_nx    = WAIT;
        wait_cnt_nx = '0;
        armed_nx    = 1'b0;
      end
      WAIT: begin
        // A done already high on entry belongs to the previous vector; arm on a low first.
        if (armed && sig_in_done) begin
          state_nx = CHECK;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx    = NEXT;
          fail_evt    = 1'b1;
          timeout_evt = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + WAIT_ONE;
          armed_nx    = armed | ~sig_in_done;
        end
      end
      CHECK: begin
        state_nx = NEXT;
        if (sig_in_valid) begin
          pass_evt = 1'b1;
        end else begin
          fail_evt = 1'b1;
        end
      end
      NEXT: begin
        if (seq_selected == LAST_ADDR) begin
          state_nx = DONE;
        end else begin
          state_nx     = SETUP;
          addr_nx      = seq_selected + ADDR_ONE;
          setup_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Result counters and sticky flags
  always_comb begin
    pass_nx       = vec_out_pass_cnt;
    fail_nx       = vec_out_fail_cnt;
    first_fail_nx = vec_out_first_fail;
    any_fail_nx   = sig_out_any_fail;
    timeout_nx    = sig_out_timeout;

    if (clear_run) begin
      pass_nx       = '0;
      fail_nx       = '0;
      first_fail_nx = '0;
      any_fail_nx   = 1'b0;
      timeout_nx    = 1'b0;
    end else if (fail_evt) begin
      fail_nx    = vec_out_fail_cnt + CNT_ONE;
      timeout_nx = sig_out_timeout | timeout_evt;
      if (!sig_out_any_fail) begin
        first_fail_nx = seq_selected;
        any_fail_nx   = 1'b1;
      end else begin
        first_fail_nx = vec_out_first_fail;
        any_fail_nx   = sig_out_any_fail;
      end
    end else if (pass_evt) begin
      pass_nx = vec_out_pass_cnt + CNT_ONE;
    end else begin
      pass_nx = vec_out_pass_cnt;
      fail_nx = vec_out_fail_cnt;
    end
  end

  // Status strobes follow the state being entered so they register in step with it
  always_comb begin
    load_nx     = 1'b0;
    busy_nx     = 1'b0;
    finished_nx = 1'b0;
    case (state_nx)
      IDLE:    begin busy_nx = 1'b0; end
      SETUP:   begin busy_nx = 1'b1; end
      LOAD:    begin busy_nx = 1'b1; load_nx = 1'b1; end
      WAIT:    begin busy_nx = 1'b1; end
      CHECK:   begin busy_nx = 1'b1; end
      NEXT:    begin busy_nx = 1'b1; end
      DONE:    begin finished_nx = 1'b1; end
      default: begin busy_nx = 1'b0; end
    endcase
  end

  // State and output registers
  always_ff @(posedge sig_mstr_clk or posedge sig_in_rst) begin
    if (sig_in_rst) begin
      state              <= IDLE;
      setup_cnt          <= '0;
      wait_cnt           <= '0;
      armed              <= 1'b0;
      seq_selected       <= '0;
      sig_out_load       <= 1'b0;
      sig_out_busy       <= 1'b0;
      sig_out_finished   <= 1'b0;
      vec_out_pass_cnt   <= '0;
      vec_out_fail_cnt   <= '0;
      vec_out_first_fail <= '0;
      sig_out_any_fail   <= 1'b0;
      sig_out_timeout    <= 1'b0;
    end else begin
      state              <= state_nx;
      setup_cnt          <= setup_cnt_nx;
      wait_cnt           <= wait_cnt_nx;
      armed              <= armed_nx;
      seq_selected       <= addr_nx;
      sig_out_load       <= load_nx;
      sig_out_busy       <= busy_nx;
      sig_out_finished   <= finished_nx;
      vec_out_pass_cnt   <= pass_nx;
      vec_out_fail_cnt   <= fail_nx;
      vec_out_first_fail <= first_fail_nx;
      sig_out_any_fail   <= any_fail_nx;
      sig_out_timeout    <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_present_test_sequencer.sv
// Self-checking bench for present_test_sequencer: a behavioural core/checker model drives
// done/valid, a scoreboard holds expected load addresses and end-of-run results.
module tb_present_test_sequencer;

  localparam int N = 4;

  typedef struct packed {
    logic [2:0] pass;
    logic [2:0] fail;
    logic [1:0] ff;
    logic       any;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       done;
  logic       valid;
  logic [1:0] seq_selected;
  logic       load;
  logic       busy;
  logic       finished;
  logic [2:0] pass_cnt;
  logic [2:0] fail_cnt;
  logic [1:0] first_fail;
  logic       any_fail;
  logic       timeout;

  int         total = 0;
  int         bad = 0;
  int         rd_idx = 0;
  int         load_cycles = 0;
  logic [1:0] obs_addr [256];
  logic [1:0] addr_q [$];
  exp_t       res_q [$];
  bit         pass_tbl [N];
  int         hang_addr = -1;
  bit         stale_mode = 1'b0;

  always #5 clk = ~clk;

  present_test_sequencer #(
    .TEST_CASE_SIZE(4),
    .SETUP_CYCLES  (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .sig_mstr_clk      (clk),
    .sig_in_rst        (rst),
    .sig_in_start      (start),
    .sig_in_done       (done),
    .sig_in_valid      (valid),
    .seq_selected      (seq_selected),
    .sig_out_load      (load),
    .sig_out_busy      (busy),
    .sig_out_finished  (finished),
    .vec_out_pass_cnt  (pass_cnt),
    .vec_out_fail_cnt  (fail_cnt),
    .vec_out_first_fail(first_fail),
    .sig_out_any_fail  (any_fail),
    .sig_out_timeout   (timeout)
  );

  // Core model: done 3 cycles after load; stale mode keeps done high and dips it once.
  initial begin
    int cd;
    cd = 0;
    done = 1'b0;
    valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        cd = 0;
        done = 1'b0;
        valid = 1'b0;
      end else if (load === 1'b1) begin
        cd = 3;
        done = stale_mode;
        valid = stale_mode ? 1'b0 : pass_tbl[seq_selected];
      end else if (cd != 0) begin
        cd = cd - 1;
        if (stale_mode && cd == 1) done = 1'b0;
        if (cd == 0 && int'(seq_selected) != hang_addr) begin
          done = 1'b1;
          valid = pass_tbl[seq_selected];
        end
      end else if (busy !== 1'b1) begin
        done = stale_mode;
      end
    end
  end

  // Load monitor: one entry per cycle that load is high
  initial begin
    forever begin
      @(negedge clk);
      if (load === 1'b1) begin
        if (load_cycles < 256) obs_addr[load_cycles] = seq_selected;
        load_cycles = load_cycles + 1;
      end
    end
  end

  task automatic push_loads(input int n);
    for (int a = 0; a < n; a++) addr_q.push_back(2'(a % N));
  endtask

  task automatic push_result(input logic [2:0] p, input logic [2:0] f, input logic [1:0] ff,
                             input logic any, input logic to);
    res_q.push_back({p, f, ff, any, to});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finished(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (finished === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({seq_selected, load, busy, finished, pass_cnt, fail_cnt, first_fail, any_fail, timeout} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%0b load=%0b fin=%0b pass=%0d fail=%0d want all 0",
               busy, load, finished, pass_cnt, fail_cnt);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({seq_selected, load, busy, finished, pass_cnt, fail_cnt} !== 10'd0) begin
      bad++;
      $display("FAIL reset_idle_hold got busy=%0b load=%0b fin=%0b want 0 0 0", busy, load, finished);
    end
  endtask

  task automatic run_and_check(input string name, input bit [3:0] tbl, input int hang, input bit stale);
    bit ok;
    exp_t r;
    logic [1:0] ea;
    for (int a = 0; a < N; a++) pass_tbl[a] = tbl[a];
    hang_addr = hang;
    stale_mode = stale;
    @(negedge clk);
    pulse_start();
    total++;
    if (busy !== 1'b1 || seq_selected !== 2'd0 || finished !== 1'b0 || pass_cnt !== 3'd0 || fail_cnt !== 3'd0) begin
      bad++;
      $display("FAIL %s_start got busy=%0b addr=%0d fin=%0b pass=%0d fail=%0d want 1 0 0 0 0",
               name, busy, seq_selected, finished, pass_cnt, fail_cnt);
    end
    wait_finished(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL %s_finish got finished=%0b want 1 within budget", name, finished);
    end
    while (addr_q.size() > 0) begin
      ea = addr_q.pop_front();
      total++;
      if (obs_addr[rd_idx] !== ea) begin
        bad++;
        $display("FAIL %s_load got addr=%0d want %0d (load %0d)", name, obs_addr[rd_idx], ea, rd_idx);
      end
      rd_idx++;
    end
    total++;
    if (load_cycles !== rd_idx) begin
      bad++;
      $display("FAIL %s_load_cycles got %0d want %0d", name, load_cycles, rd_idx);
      rd_idx = load_cycles;
    end
    r = res_q.pop_front();
    total++;
    if (pass_cnt !== r.pass || fail_cnt !== r.fail || first_fail !== r.ff || any_fail !== r.any ||
        timeout !== r.to || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_result got pass=%0d fail=%0d ff=%0d any=%0b to=%0b busy=%0b want pass=%0d fail=%0d ff=%0d any=%0b to=%0b busy=0",
               name, pass_cnt, fail_cnt, first_fail, any_fail, timeout, busy, r.pass, r.fail, r.ff, r.any, r.to);
    end
    stale_mode = 1'b0;
  endtask

  task automatic test_all_pass();
    push_loads(4);
    push_result(3'd4, 3'd0, 2'd0, 1'b0, 1'b0);
    run_and_check("all_pass", 4'b1111, -1, 1'b0);
  endtask

  task automatic test_compare_fail();
    push_loads(4);
    push_result(3'd2, 3'd2, 2'd1, 1'b1, 1'b0);
    run_and_check("compare_fail", 4'b0101, -1, 1'b0);
  endtask

  task automatic test_timeout();
    push_loads(4);
    push_result(3'd3, 3'd1, 2'd2, 1'b1, 1'b1);
    run_and_check("timeout", 4'b1111, 2, 1'b0);
  endtask

  task automatic test_stale_done();
    push_loads(4);
    push_result(3'd4, 3'd0, 2'd0, 1'b0, 1'b0);
    run_and_check("stale_done", 4'b1111, -1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    logic [1:0] ea;
    for (int a = 0; a < N; a++) pass_tbl[a] = 1'b1;
    hang_addr = -1;
    push_loads(3);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (load === 1'b1 && seq_selected === 2'd2) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_reach got no load at addr 2 want load at addr 2");
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({seq_selected, load, busy, finished, pass_cnt, fail_cnt, first_fail, any_fail, timeout} !== 15'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got addr=%0d busy=%0b pass=%0d fail=%0d want all 0",
               seq_selected, busy, pass_cnt, fail_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || load !== 1'b0 || finished !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_idle got busy=%0b load=%0b fin=%0b want 0 0 0", busy, load, finished);
    end
    while (addr_q.size() > 0) begin
      ea = addr_q.pop_front();
      total++;
      if (obs_addr[rd_idx] !== ea) begin
        bad++;
        $display("FAIL reset_mid_load got addr=%0d want %0d (load %0d)", obs_addr[rd_idx], ea, rd_idx);
      end
      rd_idx++;
    end
    rd_idx = load_cycles;
    push_loads(4);
    push_result(3'd4, 3'd0, 2'd0, 1'b0, 1'b0);
    run_and_check("after_reset", 4'b1111, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_t r;
    logic [1:0] ea;
    for (int a = 0; a < N; a++) pass_tbl[a] = 1'b1;
    hang_addr = -1;
    // Start pulsed mid-run must not disturb the walk
    push_loads(4);
    push_result(3'd4, 3'd0, 2'd0, 1'b0, 1'b0);
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (seq_selected === 2'd1) break;
    end
    pulse_start();
    wait_finished(ok);
    r = res_q.pop_front();
    total++;
    if (ok !== 1'b1 || pass_cnt !== r.pass || fail_cnt !== r.fail) begin
      bad++;
      $display("FAIL busy_start_result got fin=%0b pass=%0d fail=%0d want 1 %0d %0d", finished, pass_cnt, fail_cnt, r.pass, r.fail);
    end
    // Start held high: soak restart straight out of DONE
    push_loads(8);
    push_result(3'd4, 3'd0, 2'd0, 1'b0, 1'b0);
    push_result(3'd4, 3'd0, 2'd0, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || finished !== 1'b0 || pass_cnt !== 3'd0 || seq_selected !== 2'd0) begin
      bad++;
      $display("FAIL soak_start got busy=%0b fin=%0b pass=%0d addr=%0d want 1 0 0 0", busy, finished, pass_cnt, seq_selected);
    end
    wait_finished(ok);
    r = res_q.pop_front();
    total++;
    if (ok !== 1'b1 || pass_cnt !== r.pass || fail_cnt !== r.fail) begin
      bad++;
      $display("FAIL soak_run1 got fin=%0b pass=%0d fail=%0d want 1 %0d %0d", finished, pass_cnt, fail_cnt, r.pass, r.fail);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || finished !== 1'b0 || pass_cnt !== 3'd0 || fail_cnt !== 3'd0 || seq_selected !== 2'd0) begin
      bad++;
      $display("FAIL soak_restart got busy=%0b fin=%0b pass=%0d fail=%0d addr=%0d want 1 0 0 0 0",
               busy, finished, pass_cnt, fail_cnt, seq_selected);
    end
    start = 1'b0;
    wait_finished(ok);
    r = res_q.pop_front();
    total++;
    if (ok !== 1'b1 || pass_cnt !== r.pass || fail_cnt !== r.fail || busy !== 1'b0) begin
      bad++;
      $display("FAIL soak_run2 got fin=%0b pass=%0d fail=%0d busy=%0b want 1 %0d %0d 0", finished, pass_cnt, fail_cnt, busy, r.pass, r.fail);
    end
    while (addr_q.size() > 0) begin
      ea = addr_q.pop_front();
      total++;
      if (obs_addr[rd_idx] !== ea) begin
        bad++;
        $display("FAIL back_to_back_load got addr=%0d want %0d (load %0d)", obs_addr[rd_idx], ea, rd_idx);
      end
      rd_idx++;
    end
    total++;
    if (load_cycles !== rd_idx) begin
      bad++;
      $display("FAIL back_to_back_load_cycles got %0d want %0d", load_cycles, rd_idx);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_all_pass();
    test_compare_fail();
    test_timeout();
    test_stale_done();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
